// File: rtl/cmp_swap_responder.sv
// Compare-and-swap responder for the bubble-sort datapath: one j per request, swaps
// mem[j]/mem[j+1] when out of order, then pulses o_ack. Define CMP_SWAP_SIGNED_EN for a signed compare.
module cmp_swap_responder #(
   parameter int SIZE_ADDR = 8,
   parameter int DATA_W    = 16,
   parameter int CNT_W     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [SIZE_ADDR-1:0] i_num_elems,
   input  logic                 i_req,
   input  logic [SIZE_ADDR-1:0] i_value_j,
   output logic                 o_busy,
   output logic                 o_rd_en,
   output logic [SIZE_ADDR-1:0] o_rd_addr,
   input  logic [DATA_W-1:0]    i_rd_data,
   output logic                 o_wr_en,
   output logic [SIZE_ADDR-1:0] o_wr_addr,
   output logic [DATA_W-1:0]    o_wr_data,
   output logic                 o_ack,
   output logic                 o_swapped,
   output logic                 o_oob,
   input  logic                 i_clr_cnt,
   output logic [CNT_W-1:0]     o_swap_cnt,
   output logic [2:0]           o_state
);

   // Handshake: i_req is honoured only in IDLE (o_busy low); every accepted request
   // ends with exactly one o_ack pulse unless reset intervenes.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_A = 3'd1,
      S_RD_B = 3'd2,
      S_CAP  = 3'd3,
      S_CMP  = 3'd4,
      S_WR_A = 3'd5,
      S_WR_B = 3'd6,
      S_ACK  = 3'd7
   } state_t;

   state_t               state;
   logic [SIZE_ADDR-1:0] j_q;
   logic [DATA_W-1:0]    a_q;
   logic [DATA_W-1:0]    b_q;
   logic                 oob_q;
   logic [SIZE_ADDR:0]   req_j_inc;
   logic                 req_oob;
   logic                 a_gt_b;

   // One extra bit so j = all-ones is out of bounds instead of wrapping to 0.
   assign req_j_inc = {1'b0, i_value_j} + (SIZE_ADDR + 1)'(1);
   assign req_oob   = (req_j_inc >= {1'b0, i_num_elems});

`ifdef CMP_SWAP_SIGNED_EN
   assign a_gt_b = ($signed(a_q) > $signed(b_q));
`else
   assign a_gt_b = (a_q > b_q);
`endif

   assign o_state = state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         j_q        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         oob_q      <= 1'b0;
         o_busy     <= 1'b0;
         o_rd_en    <= 1'b0;
         o_rd_addr  <= '0;
         o_wr_en    <= 1'b0;
         o_wr_addr  <= '0;
         o_wr_data  <= '0;
         o_ack      <= 1'b0;
         o_swapped  <= 1'b0;
         o_oob      <= 1'b0;
         o_swap_cnt <= '0;
      end else begin
         o_rd_en   <= 1'b0;
         o_wr_en   <= 1'b0;
         o_ack     <= 1'b0;
         o_swapped <= 1'b0;
         o_oob     <= 1'b0;

         if (i_clr_cnt)
            o_swap_cnt <= '0;
         else if (state == S_WR_B && o_swap_cnt != {CNT_W{1'b1}})
            o_swap_cnt <= o_swap_cnt + CNT_W'(1);

         case (state)
            S_IDLE: begin
               if (i_req) begin
                  j_q    <= i_value_j;
                  o_busy <= 1'b1;
                  oob_q  <= req_oob;
                  if (req_oob) begin
                     // Skip the RAM entirely; CMP turns this into an oob ack.
                     state <= S_CMP;
                  end else begin
                     state     <= S_RD_A;
                     o_rd_en   <= 1'b1;
                     o_rd_addr <= i_value_j;
                  end
               end
            end
            S_RD_A: begin
               state     <= S_RD_B;
               o_rd_en   <= 1'b1;
               o_rd_addr <= j_q + SIZE_ADDR'(1);
            end
            S_RD_B: begin
               state <= S_CAP;
               a_q   <= i_rd_data;
            end
            S_CAP: begin
               state <= S_CMP;
               b_q   <= i_rd_data;
            end
            S_CMP: begin
               if (!oob_q && a_gt_b) begin
                  state     <= S_WR_A;
                  o_wr_en   <= 1'b1;
                  o_wr_addr <= j_q;
                  o_wr_data <= b_q;
               end else begin
                  state <= S_ACK;
                  o_ack <= 1'b1;
                  o_oob <= oob_q;
               end
            end
            S_WR_A: begin
               state     <= S_WR_B;
               o_wr_en   <= 1'b1;
               o_wr_addr <= j_q + SIZE_ADDR'(1);
               o_wr_data <= a_q;
            end
            S_WR_B: begin
               state     <= S_ACK;
               o_ack     <= 1'b1;
               o_swapped <= 1'b1;
            end
            S_ACK: begin
               state  <= S_IDLE;
               o_busy <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_swap_responder.sv
// Directed bench for cmp_swap_responder with a behavioural single-port RAM and an
// in-bench I/J loop driving a full bubble sort.
module tb_cmp_swap_responder;

   logic        clk;
   logic        i_rst;
   logic [7:0]  i_num_elems;
   logic        i_req;
   logic [7:0]  i_value_j;
   logic        o_busy;
   logic        o_rd_en;
   logic [7:0]  o_rd_addr;
   logic [15:0] i_rd_data;
   logic        o_wr_en;
   logic [7:0]  o_wr_addr;
   logic [15:0] o_wr_data;
   logic        o_ack;
   logic        o_swapped;
   logic        o_oob;
   logic        i_clr_cnt;
   logic [15:0] o_swap_cnt;
   logic [2:0]  o_state;

   logic [15:0] mem [0:255];

   int n_checks;
   int n_errors;

   // Results of the most recent do_req
   int          lat;
   int          n_acks;
   int          overlap;
   int          busy_gap;
   logic        ack_swapped;
   logic        ack_oob;
   logic [15:0] ack_cnt;
   logic [7:0]  rd_log [$];
   logic [7:0]  wr_addr_log [$];
   logic [15:0] wr_data_log [$];

   cmp_swap_responder #(.SIZE_ADDR(8), .DATA_W(16), .CNT_W(16)) dut (
      .i_clk(clk),
      .i_rst(i_rst),
      .i_num_elems(i_num_elems),
      .i_req(i_req),
      .i_value_j(i_value_j),
      .o_busy(o_busy),
      .o_rd_en(o_rd_en),
      .o_rd_addr(o_rd_addr),
      .i_rd_data(i_rd_data),
      .o_wr_en(o_wr_en),
      .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data),
      .o_ack(o_ack),
      .o_swapped(o_swapped),
      .o_oob(o_oob),
      .i_clr_cnt(i_clr_cnt),
      .o_swap_cnt(o_swap_cnt),
      .o_state(o_state)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // single-port RAM, read data one cycle after o_rd_en
   always @(posedge clk) begin
      if (o_rd_en) i_rd_data <= mem[o_rd_addr];
      if (o_wr_en) mem[o_wr_addr] = o_wr_data;
   end

   // driver: issue one request and observe until ack (or budget expires)
   task automatic do_req(input logic [7:0] j);
      @(negedge clk);
      i_req     = 1'b1;
      i_value_j = j;
      @(posedge clk);
      #1 i_req  = 1'b0;
      lat = 0; n_acks = 0; overlap = 0; busy_gap = 0;
      ack_swapped = 1'b0; ack_oob = 1'b0; ack_cnt = '0;
      rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (o_rd_en) rd_log.push_back(o_rd_addr);
         if (o_wr_en) begin
            wr_addr_log.push_back(o_wr_addr);
            wr_data_log.push_back(o_wr_data);
         end
         if (o_rd_en && o_wr_en) overlap++;
         if (!o_busy) busy_gap++;
         if (o_ack) begin
            n_acks++;
            lat = c;
            ack_swapped = o_swapped;
            ack_oob = o_oob;
            ack_cnt = o_swap_cnt;
            break;
         end
      end
   endtask

   task automatic load_mem(input logic [15:0] v0, v1, v2, v3, v4);
      mem[0] = v0; mem[1] = v1; mem[2] = v2; mem[3] = v3; mem[4] = v4;
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      i_rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (o_state !== 3'd0) begin n_errors++; $display("FAIL reset_state got %0d want 0", o_state); end
      n_checks++;
      if ({o_busy, o_rd_en, o_wr_en, o_ack, o_swapped, o_oob} !== 6'b0) begin
         n_errors++; $display("FAIL reset_flags got %b want 000000", {o_busy, o_rd_en, o_wr_en, o_ack, o_swapped, o_oob});
      end
      n_checks++;
      if (o_swap_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt got %0d want 0", o_swap_cnt); end
   endtask

   task automatic test_swap;
      load_mem(16'd9, 16'd3, 16'd4, 16'd7, 16'd1);
      do_req(8'd0);
      n_checks++;
      if (lat !== 7) begin n_errors++; $display("FAIL swap_latency got %0d want 7", lat); end
      n_checks++;
      if ({ack_swapped, ack_oob} !== 2'b10) begin n_errors++; $display("FAIL swap_flags got %b want 10", {ack_swapped, ack_oob}); end
      n_checks++;
      if (rd_log.size() != 2 || rd_log[0] !== 8'd0 || rd_log[1] !== 8'd1) begin
         n_errors++; $display("FAIL swap_reads got %p want '{0,1}", rd_log);
      end
      n_checks++;
      if (wr_addr_log.size() != 2 || wr_addr_log[0] !== 8'd0 || wr_data_log[0] !== 16'd3
          || wr_addr_log[1] !== 8'd1 || wr_data_log[1] !== 16'd9) begin
         n_errors++; $display("FAIL swap_writes got addr %p data %p want addr 0,1 data 3,9", wr_addr_log, wr_data_log);
      end
      n_checks++;
      if (mem[0] !== 16'd3 || mem[1] !== 16'd9) begin
         n_errors++; $display("FAIL swap_mem got %0d,%0d want 3,9", mem[0], mem[1]);
      end
      n_checks++;
      if (ack_cnt !== 16'd1) begin n_errors++; $display("FAIL swap_cnt got %0d want 1", ack_cnt); end
      n_checks++;
      if (overlap !== 0 || busy_gap !== 0) begin
         n_errors++; $display("FAIL swap_busy_excl got overlap %0d busy_gap %0d want 0 0", overlap, busy_gap);
      end
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b0 || o_ack !== 1'b0) begin
         n_errors++; $display("FAIL swap_after_ack got busy %b ack %b want 0 0", o_busy, o_ack);
      end
   endtask

   task automatic test_no_swap;
      load_mem(16'd3, 16'd9, 16'd4, 16'd7, 16'd1);
      do_req(8'd2);
      n_checks++;
      if (lat !== 5) begin n_errors++; $display("FAIL noswap_latency got %0d want 5", lat); end
      n_checks++;
      if ({ack_swapped, ack_oob} !== 2'b00) begin n_errors++; $display("FAIL noswap_flags got %b want 00", {ack_swapped, ack_oob}); end
      n_checks++;
      if (rd_log.size() != 2 || rd_log[0] !== 8'd2 || rd_log[1] !== 8'd3 || wr_addr_log.size() != 0) begin
         n_errors++; $display("FAIL noswap_access got rd %p wr %p want rd 2,3 no wr", rd_log, wr_addr_log);
      end
      n_checks++;
      if (mem[2] !== 16'd4 || mem[3] !== 16'd7) begin
         n_errors++; $display("FAIL noswap_mem got %0d,%0d want 4,7", mem[2], mem[3]);
      end
   endtask

   task automatic test_equal;
      load_mem(16'd3, 16'd5, 16'd5, 16'd7, 16'd1);
      do_req(8'd1);
      n_checks++;
      if (lat !== 5 || ack_swapped !== 1'b0 || wr_addr_log.size() != 0) begin
         n_errors++; $display("FAIL equal_noswap got lat %0d swapped %b writes %0d want 5 0 0", lat, ack_swapped, wr_addr_log.size());
      end
   endtask

   task automatic test_oob;
      logic [7:0] js [2];
      js[0] = 8'd4;
      js[1] = 8'd255;
      for (int k = 0; k < 2; k++) begin
         do_req(js[k]);
         n_checks++;
         if (lat !== 2 || ack_oob !== 1'b1 || ack_swapped !== 1'b0) begin
            n_errors++; $display("FAIL oob_j%0d got lat %0d oob %b swapped %b want 2 1 0", js[k], lat, ack_oob, ack_swapped);
         end
         n_checks++;
         if (rd_log.size() != 0 || wr_addr_log.size() != 0) begin
            n_errors++; $display("FAIL oob_access_j%0d got rd %0d wr %0d want 0 0", js[k], rd_log.size(), wr_addr_log.size());
         end
      end
   endtask

   task automatic test_busy_ignore;
      int acks;
      load_mem(16'd8, 16'd2, 16'd4, 16'd7, 16'd1);
      acks = 0;
      @(negedge clk);
      i_req = 1'b1; i_value_j = 8'd0;
      @(negedge clk);
      i_req = 1'b0;
      @(negedge clk);
      i_req = 1'b1; i_value_j = 8'd2;
      if (o_ack) acks++;
      @(negedge clk);
      i_req = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (o_ack) acks++;
         @(negedge clk);
      end
      n_checks++;
      if (acks !== 1) begin n_errors++; $display("FAIL busy_ignore_acks got %0d want 1", acks); end
      n_checks++;
      if (mem[0] !== 16'd2 || mem[1] !== 16'd8 || mem[2] !== 16'd4 || mem[3] !== 16'd7) begin
         n_errors++; $display("FAIL busy_ignore_mem got %0d,%0d,%0d,%0d want 2,8,4,7", mem[0], mem[1], mem[2], mem[3]);
      end
   endtask

   task automatic test_reset_mid;
      int acks;
      int waited;
      load_mem(16'd9, 16'd3, 16'd4, 16'd7, 16'd1);
      acks = 0;
      waited = 0;
      @(negedge clk);
      i_req = 1'b1; i_value_j = 8'd0;
      @(negedge clk);
      i_req = 1'b0;
      while (!o_wr_en && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (o_wr_en !== 1'b1 || o_state !== 3'd5) begin
         n_errors++; $display("FAIL rstmid_reach_wra got wr_en %b state %0d want 1 5", o_wr_en, o_state);
      end
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      n_checks++;
      if (o_state !== 3'd0 || o_busy !== 1'b0) begin
         n_errors++; $display("FAIL rstmid_idle got state %0d busy %b want 0 0", o_state, o_busy);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (o_ack) acks++;
      end
      n_checks++;
      if (acks !== 0) begin n_errors++; $display("FAIL rstmid_no_ack got %0d want 0", acks); end
      n_checks++;
      if (mem[0] !== 16'd3 || mem[1] !== 16'd3) begin
         n_errors++; $display("FAIL rstmid_half_write got %0d,%0d want 3,3", mem[0], mem[1]);
      end
   endtask

   task automatic test_clr_cnt;
      load_mem(16'd9, 16'd3, 16'd4, 16'd7, 16'd1);
      do_req(8'd0);
      do_req(8'd1);
      n_checks++;
      if (o_swap_cnt !== 16'd2) begin n_errors++; $display("FAIL cnt_two got %0d want 2", o_swap_cnt); end
      @(negedge clk);
      i_clr_cnt = 1'b1;
      @(negedge clk);
      n_checks++;
      if (o_swap_cnt !== 16'd0) begin n_errors++; $display("FAIL cnt_clear got %0d want 0", o_swap_cnt); end
      load_mem(16'd9, 16'd3, 16'd4, 16'd7, 16'd1);
      do_req(8'd0);
      n_checks++;
      if (ack_swapped !== 1'b1 || ack_cnt !== 16'd0) begin
         n_errors++; $display("FAIL cnt_clr_wins got swapped %b cnt %0d want 1 0", ack_swapped, ack_cnt);
      end
      i_clr_cnt = 1'b0;
   endtask

   task automatic test_sort;
      logic [15:0] exp_v [5];
`ifdef CMP_SWAP_SIGNED_EN
      exp_v[0] = 16'hFFFF; exp_v[1] = 16'd1; exp_v[2] = 16'd3; exp_v[3] = 16'd5; exp_v[4] = 16'd9;
`else
      exp_v[0] = 16'd1; exp_v[1] = 16'd3; exp_v[2] = 16'd5; exp_v[3] = 16'd9; exp_v[4] = 16'hFFFF;
`endif
      load_mem(16'd9, 16'hFFFF, 16'd3, 16'd5, 16'd1);
      i_num_elems = 8'd5;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4 - i; j++) begin
            do_req(8'(j));
            n_checks++;
            if (n_acks !== 1) begin n_errors++; $display("FAIL sort_ack_i%0d_j%0d got %0d want 1", i, j, n_acks); end
         end
      end
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (mem[k] !== exp_v[k]) begin
            n_errors++; $display("FAIL sort_mem%0d got %h want %h", k, mem[k], exp_v[k]);
         end
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      i_rst       = 1'b1;
      i_num_elems = 8'd5;
      i_req       = 1'b0;
      i_value_j   = 8'd0;
      i_clr_cnt   = 1'b0;
      i_rd_data   = 16'd0;
      for (int k = 0; k < 256; k++) mem[k] = 16'd0;

      test_reset;
      test_swap;
      test_no_swap;
      test_equal;
      test_oob;
      test_busy_ignore;
      test_reset_mid;
      test_clr_cnt;
      test_sort;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
